// File: rtl/output_capture_pkg.sv
// output_capture_pkg: shared sizing defaults, capture FSM encoding and helpers
package output_capture_pkg;

    localparam int NB_DEF      = 12;
    localparam int DEPTH_DEF   = 16;
    localparam int IDLE_TO_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/output_capture_fifo.sv
// capture_fifo: sample storage with wrapping pointers, occupancy and registered read port
module capture_fifo #(
    parameter int NB    = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [NB-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [NB-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NB-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [NB-1:0] rd_data_q, rd_data_d;

    // Pointer, occupancy and read-data next state; callers only assert wr_en/rd_en when legal
    always_comb begin
        wr_ptr_d  = clr ? '0 : (wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q);
        rd_ptr_d  = clr ? '0 : (rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q);
        count_d   = clr ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
        rd_data_d = clr ? '0 : (rd_en ? mem_q[rd_ptr_q] : rd_data_q);
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;

endmodule

// File: rtl/output_capture.sv
// output_capture: buffers filter samples, tracks overflow and detects end of a capture run
module output_capture
    import output_capture_pkg::*;
#(
    parameter int NB      = NB_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int IDLE_TO = IDLE_TO_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vIn,
    input  logic [NB-1:0]          dIn,
    input  logic                   clr,
    input  logic                   rdEn,
    output logic [NB-1:0]          rdData,
    output logic                   rdValid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic [7:0]             ovfCnt,
    output logic                   done
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(IDLE_TO + 1);

    cap_state_e    state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic          full, rd_acc, wr_acc, drop;

    // A full buffer still accepts a write when a read frees a slot in the same cycle
    assign full   = count == CW'(DEPTH);
    assign rd_acc = rdEn && !clr && (count != '0);
    assign wr_acc = vIn && !clr && (!full || rd_acc);
    assign drop   = vIn && !clr && full && !rd_acc;

    capture_fifo #(
        .NB    (NB),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_en   (wr_acc),
        .wr_data (dIn),
        .rd_en   (rd_acc),
        .rd_data (rdData),
        .count   (count)
    );

    // Capture FSM and idle counter next state; clear wins over everything
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        if (clr) begin
            state_d = ST_IDLE;
            idle_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = vIn ? ST_CAPTURE : ST_IDLE;
                    idle_d  = '0;
                end
                ST_CAPTURE: begin
                    idle_d  = vIn ? '0 : idle_q + 1'b1;
                    state_d = (!vIn && idle_q == IW'(IDLE_TO - 1)) ? ST_DONE : ST_CAPTURE;
                end
                ST_DONE: begin
                    state_d = vIn ? ST_CAPTURE : ST_DONE;
                    idle_d  = vIn ? '0 : idle_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    idle_d  = '0;
                end
            endcase
        end
    end

    // Overflow tracking and read-valid pulse next state
    always_comb begin
        ovf_d      = clr ? 1'b0 : (ovf_q | drop);
        ovf_cnt_d  = clr ? 8'd0 : (drop ? sat_inc8(ovf_cnt_q) : ovf_cnt_q);
        rd_valid_d = rd_acc;
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idle_q     <= '0;
            ovf_q      <= 1'b0;
            ovf_cnt_q  <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            ovf_q      <= ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rdValid = rd_valid_q;
    assign ovf     = ovf_q;
    assign ovfCnt  = ovf_cnt_q;
    assign done    = state_q == ST_DONE;

endmodule
